// File: rtl/sdram_demo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sdram_demo_pkg
// Description : Shared types and ramp-pattern helper for the SDRAM demo.
// Revision    : 1.0 - initial release
// ============================================================================
package sdram_demo_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int NWORDS_DEF = 256;
  localparam int IDX_W      = $clog2(NWORDS_DEF);

  // Word the write side stores at position idx; low byte wraps modulo 256.
  function automatic logic [15:0] ramp_word(input logic [7:0] seed, input logic [7:0] idx);
    logic [7:0] b;
    b = seed + idx;
    return {8'h00, b};
  endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_readback_checker_rd_lat_pipe.sv
`default_nettype none
// ============================================================================
// Module      : rd_lat_pipe
// Description : DEPTH-deep shift register of read strobes; tail marks data valid.
// Revision    : 1.0 - initial release
// ============================================================================
module rd_lat_pipe #(
  parameter int DEPTH = 1
) (
  input  logic clk_i,
  input  logic clr_i,
  input  logic in_i,
  output logic out_o
);

  logic [DEPTH-1:0] pipe_q;

  generate
    if (DEPTH == 1) begin : g_one
      always_ff @(posedge clk_i) begin
        if (clr_i) pipe_q <= '0;
        else       pipe_q <= in_i;
      end
    end else begin : g_multi
      always_ff @(posedge clk_i) begin
        if (clr_i) pipe_q <= '0;
        else       pipe_q <= {pipe_q[DEPTH-2:0], in_i};
      end
    end
  endgenerate

  assign out_o = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/sdram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : sdram_readback_checker
// Description : Pops NWORDS words from the read FIFO and checks them against the ramp.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_readback_checker
  import sdram_demo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NWORDS = 256,
  parameter int RD_LAT = 1,
  parameter int SEED   = 0
) (
  input  logic                      ref_clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      rd_rdy_i,
  output logic                      rd_o,
  input  logic [DATA_W-1:0]         rd_data_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      pass_o,
  output logic [$clog2(NWORDS):0]   err_cnt_o,
  output logic [$clog2(NWORDS)-1:0] first_err_idx_o,
  output logic [DATA_W-1:0]         first_err_data_o,
  output logic [15:0]               disp_o
);

  localparam int         IW     = $clog2(NWORDS);
  localparam logic [IW:0] N_CNT  = (IW+1)'(NWORDS);
  localparam logic [IW:0] N_LAST = (IW+1)'(NWORDS - 1);

  state_e              state_q, state_d;
  logic [IW:0]         issued_q, issued_d;
  logic [IW:0]         infl_q, infl_d;
  logic [IW-1:0]       chk_q, chk_d;
  logic [IW:0]         err_q, err_d;
  logic [IW-1:0]       ferr_idx_q, ferr_idx_d;
  logic [DATA_W-1:0]   ferr_data_q, ferr_data_d;
  logic [DATA_W-1:0]   last_q, last_d;
  logic                pass_q, pass_d;

  logic                w_busy;
  logic                w_rd;
  logic                w_strobe;
  logic                w_cmp;
  logic [15:0]         w_ramp;
  logic [DATA_W-1:0]   w_exp;
  logic                w_mis;

  assign w_busy = (state_q == ISSUE) || (state_q == DRAIN);
  assign w_rd   = (state_q == ISSUE) && rd_rdy_i && (issued_q < N_CNT);

  rd_lat_pipe #(.DEPTH(RD_LAT)) u_pipe (
    .clk_i (ref_clk_i),
    .clr_i (reset_i),
    .in_i  (w_rd),
    .out_o (w_strobe)
  );

  // Strobes arriving outside a run carry no meaning and are dropped.
  assign w_cmp  = w_strobe && w_busy;
  assign w_ramp = ramp_word(8'(SEED), 8'(chk_q));
  assign w_exp  = DATA_W'(w_ramp);
  assign w_mis  = (rd_data_i != w_exp);

  always_comb begin
    state_d     = state_q;
    issued_d    = issued_q;
    chk_d       = chk_q;
    err_d       = err_q;
    ferr_idx_d  = ferr_idx_q;
    ferr_data_d = ferr_data_q;
    last_d      = last_q;
    pass_d      = pass_q;
    infl_d      = infl_q + (IW+1)'(w_rd) - (IW+1)'(w_cmp);

    if (w_rd) issued_d = issued_q + 1'b1;

    if (w_cmp) begin
      chk_d  = chk_q + 1'b1;
      last_d = rd_data_i;
      if (w_mis) begin
        if (err_q != N_CNT) err_d = err_q + 1'b1;
        if (err_q == '0) begin
          ferr_idx_d  = chk_q;
          ferr_data_d = rd_data_i;
        end
      end
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d     = ISSUE;
          issued_d    = '0;
          infl_d      = '0;
          chk_d       = '0;
          err_d       = '0;
          ferr_idx_d  = '0;
          ferr_data_d = '0;
          pass_d      = 1'b0;
        end
      end
      ISSUE: begin
        if (w_rd && (issued_q == N_LAST)) state_d = DRAIN;
      end
      DRAIN: begin
        if (infl_d == '0) begin
          state_d = DONE;
          pass_d  = (err_d == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      issued_q    <= '0;
      infl_q      <= '0;
      chk_q       <= '0;
      err_q       <= '0;
      ferr_idx_q  <= '0;
      ferr_data_q <= '0;
      last_q      <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      issued_q    <= issued_d;
      infl_q      <= infl_d;
      chk_q       <= chk_d;
      err_q       <= err_d;
      ferr_idx_q  <= ferr_idx_d;
      ferr_data_q <= ferr_data_d;
      last_q      <= last_d;
      pass_q      <= pass_d;
    end
  end

  assign rd_o             = w_rd;
  assign busy_o           = w_busy;
  assign done_o           = (state_q == DONE);
  assign pass_o           = pass_q;
  assign err_cnt_o        = err_q;
  assign first_err_idx_o  = ferr_idx_q;
  assign first_err_data_o = ferr_data_q;
  assign disp_o           = (state_q == DONE) ? (pass_q ? 16'h0000 : 16'(ferr_data_q))
                                              : 16'(last_q);

endmodule
`default_nettype wire

// File: tb/tb_sdram_readback_checker.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_readback_checker
// Description : Randomized self-checking bench; two checkers (RD_LAT 1 and 3) share stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_readback_checker;

  localparam int NW = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic rd_rdy = 1'b0;

  logic [1:0]  rd_w, busy_w, done_w, pass_w;
  logic [8:0]  err_w  [2];
  logic [7:0]  fidx_w [2];
  logic [15:0] fdat_w [2];
  logic [15:0] disp_w [2];
  logic [15:0] dp     [2][4];
  logic [15:0] rdd0, rdd1;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int nrd[2]       = '{0, 0};
  int viol[2]      = '{0, 0};
  int first_rd[2]  = '{-1, -1};
  int last_rd[2]   = '{-1, -1};
  int done_cyc[2]  = '{-1, -1};
  int start_cyc[2] = '{0, 0};
  int pops[2]      = '{0, 0};

  bit          corrupt [NW];
  logic [15:0] cval    [NW];

  always #5 clk = ~clk;

  assign rdd0 = dp[0][0];
  assign rdd1 = dp[1][2];

  sdram_readback_checker #(.DATA_W(16), .NWORDS(NW), .RD_LAT(1), .SEED(0)) dut_a (
    .ref_clk_i(clk), .reset_i(rst), .start_i(start), .rd_rdy_i(rd_rdy),
    .rd_o(rd_w[0]), .rd_data_i(rdd0), .busy_o(busy_w[0]), .done_o(done_w[0]),
    .pass_o(pass_w[0]), .err_cnt_o(err_w[0]), .first_err_idx_o(fidx_w[0]),
    .first_err_data_o(fdat_w[0]), .disp_o(disp_w[0])
  );

  sdram_readback_checker #(.DATA_W(16), .NWORDS(NW), .RD_LAT(3), .SEED(200)) dut_b (
    .ref_clk_i(clk), .reset_i(rst), .start_i(start), .rd_rdy_i(rd_rdy),
    .rd_o(rd_w[1]), .rd_data_i(rdd1), .busy_o(busy_w[1]), .done_o(done_w[1]),
    .pass_o(pass_w[1]), .err_cnt_o(err_w[1]), .first_err_idx_o(fidx_w[1]),
    .first_err_data_o(fdat_w[1]), .disp_o(disp_w[1])
  );

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic logic [15:0] ramp16(input int i, input int k);
    int s;
    s = (i == 0) ? 0 : 200;
    return 16'((s + k) % 256);
  endfunction

  function automatic logic [15:0] src_word(input int i, input int k);
    if (k < NW && corrupt[k]) return cval[k];
    return ramp16(i, k);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // FIFO responder and run monitor: sees each cycle's signals at its closing edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (done_w[i] && done_cyc[i] < 0) done_cyc[i] = cyc;
      if (start && !busy_w[i] && !rst) begin
        nrd[i] = 0; viol[i] = 0; first_rd[i] = -1; last_rd[i] = -1;
        done_cyc[i] = -1; start_cyc[i] = cyc; pops[i] = 0;
      end
      for (int j = 3; j > 0; j--) dp[i][j] <= dp[i][j-1];
      dp[i][0] <= rd_w[i] ? src_word(i, pops[i]) : 16'($urandom);
      if (rd_w[i]) begin
        if (!rd_rdy) viol[i]++;
        if (first_rd[i] < 0) first_rd[i] = cyc;
        last_rd[i] = cyc;
        nrd[i]++;
        pops[i]++;
      end
    end
    cyc = cyc + 1;
  end

  task automatic setup_words(input int mode);
    for (int k = 0; k < NW; k++) begin
      corrupt[k] = 1'b0;
      cval[k]    = 16'h0000;
      if (mode == 2) begin
        corrupt[k] = 1'b1;
        cval[k]    = 16'hFFFF;
      end else if (mode == 3 && $urandom_range(0, 15) == 0) begin
        corrupt[k] = 1'b1;
        cval[k]    = 16'($urandom);
      end
    end
    if (mode == 1) begin
      corrupt[5] = 1'b1;
      cval[5]    = 16'h00FF;
    end
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s%0d busy", tag, i), 32'(busy_w[i]), 0);
      chk($sformatf("%s%0d done", tag, i), 32'(done_w[i]), 0);
      chk($sformatf("%s%0d pass", tag, i), 32'(pass_w[i]), 0);
      chk($sformatf("%s%0d rd", tag, i), 32'(rd_w[i]), 0);
      chk($sformatf("%s%0d err", tag, i), 32'(err_w[i]), 0);
      chk($sformatf("%s%0d fidx", tag, i), 32'(fidx_w[i]), 0);
      chk($sformatf("%s%0d fdat", tag, i), 32'(fdat_w[i]), 0);
      chk($sformatf("%s%0d disp", tag, i), 32'(disp_w[i]), 0);
    end
  endtask

  task automatic check_result(input int i, input int rdy_mode);
    int e, fi;
    logic [15:0] fd;
    e = 0; fi = 0; fd = 16'h0000;
    for (int k = 0; k < NW; k++) begin
      if (src_word(i, k) != ramp16(i, k)) begin
        if (e == 0) begin
          fi = k;
          fd = src_word(i, k);
        end
        e++;
      end
    end
    chk($sformatf("i%0d rd_count", i), 32'(nrd[i]), NW);
    chk($sformatf("i%0d rd_while_not_rdy", i), 32'(viol[i]), 0);
    chk($sformatf("i%0d lastrd_to_done", i), 32'(done_cyc[i] - last_rd[i]), 32'(lat_of(i) + 1));
    if (rdy_mode == 0) begin
      chk($sformatf("i%0d start_to_rd", i), 32'(first_rd[i] - start_cyc[i]), 1);
      chk($sformatf("i%0d start_to_done", i), 32'(done_cyc[i] - start_cyc[i]), 32'(NW + lat_of(i) + 1));
    end
    chk($sformatf("i%0d done", i), 32'(done_w[i]), 1);
    chk($sformatf("i%0d busy", i), 32'(busy_w[i]), 0);
    chk($sformatf("i%0d err_cnt", i), 32'(err_w[i]), 32'(e));
    chk($sformatf("i%0d first_idx", i), 32'(fidx_w[i]), 32'(fi));
    chk($sformatf("i%0d first_data", i), 32'(fdat_w[i]), 32'(fd));
    chk($sformatf("i%0d pass", i), 32'(pass_w[i]), 32'(e == 0));
    chk($sformatf("i%0d disp", i), 32'(disp_w[i]), (e == 0) ? 32'h0 : 32'(fd));
  endtask

  // rdy_mode: 0 constant, 1 toggle, 2 random. reset_at >= 0 aborts the run by reset.
  task automatic run(input int mode, input int rdy_mode, input bit drain_start, input int reset_at);
    int  guard;
    bit  extra;
    setup_words(mode);
    @(negedge clk); start = 1'b1; rd_rdy = 1'b1;
    @(negedge clk); start = 1'b0;
    guard = 0;
    extra = 1'b0;
    while (!(done_cyc[0] >= 0 && done_cyc[1] >= 0) && guard < 3000) begin
      case (rdy_mode)
        0:       rd_rdy = 1'b1;
        1:       rd_rdy = ~rd_rdy;
        default: rd_rdy = ($urandom_range(0, 3) != 0);
      endcase
      if (drain_start && !extra && nrd[0] == NW && busy_w[0] && busy_w[1]) begin
        start = 1'b1;
        extra = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (reset_at >= 0 && nrd[0] == reset_at) begin
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_zero("rst_mid");
        rst = 1'b0;
        rd_rdy = 1'b1;
        repeat (6) @(negedge clk);
        check_zero("post_rst");
        return;
      end
      @(negedge clk);
      guard++;
    end
    start = 1'b0;
    chk("run_timeout", 32'(guard >= 3000), 0);
    for (int i = 0; i < 2; i++) check_result(i, rdy_mode);
    if (drain_start) begin
      chk("drain_start_seen", 32'(extra), 1);
      repeat (5) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("i%0d drain_start_ignored_busy", i), 32'(busy_w[i]), 0);
        chk($sformatf("i%0d drain_start_ignored_done", i), 32'(done_w[i]), 1);
        chk($sformatf("i%0d drain_start_ignored_rd", i), 32'(nrd[i]), NW);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 4; j++) dp[i][j] = 16'h0000;
    rst = 1'b1; start = 1'b1; rd_rdy = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0; start = 1'b0;
    @(negedge clk);

    run(0, 0, 1'b0, -1);
    run(1, 0, 1'b0, -1);
    run(0, 1, 1'b0, -1);
    run(2, 0, 1'b0, -1);
    run(0, 0, 1'b0, 100);
    run(0, 0, 1'b0, -1);
    run(0, 0, 1'b1, -1);
    for (int r = 0; r < 4; r++) run(3, 2, 1'b0, -1);
    run(1, 2, 1'b0, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
